// File: rtl/contador_regressivo.sv
// Centisecond countdown timer with BCD value 00.00-99.99, load validation and
// a three-state IDLE/RUN/DONE controller; every output comes straight from a flop.
module contador_regressivo (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        load,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] load_value,
    output logic [15:0] tempo_bcd,
    output logic        running,
    output logic        expired,
    output logic        done,
    output logic        load_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] tempo_next;
    logic        done_next;
    logic        load_err_next;
    logic        running_next;
    logic        expired_next;

    logic        load_ok;
    logic        tempo_zero;
    logic [15:0] tempo_dec;

    // True when every nibble is a legal decimal digit.
    function automatic logic digits_valid(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9)
                ok = 1'b0;
        end
        return ok;
    endfunction

    // One-centisecond BCD decrement: a zero digit becomes 9 and passes the
    // borrow up; the first non-zero digit absorbs it. Only used on non-zero values.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign load_ok    = digits_valid(load_value);
    assign tempo_zero = (tempo_bcd == 16'h0000);
    assign tempo_dec  = bcd_dec(tempo_bcd);

    // State register together with the registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tempo_bcd <= 16'h0000;
            running   <= 1'b0;
            expired   <= 1'b0;
            done      <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_next;
            tempo_bcd <= tempo_next;
            running   <= running_next;
            expired   <= expired_next;
            done      <= done_next;
            load_err  <= load_err_next;
        end
    end

    // Next-state logic. Priority load > stop > start > tick: once a higher
    // input is present the lower ones are ignored, even if it has no effect.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal; this keeps
        // the block purely combinational with no inferred latches.
        state_next    = state;
        tempo_next    = tempo_bcd;
        done_next     = 1'b0;
        load_err_next = 1'b0;

        if (load) begin
            if (load_ok) begin
                tempo_next = load_value;
                state_next = IDLE;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (stop) begin
            if (state == RUN)
                state_next = IDLE;
        end else if (start) begin
            if (state == IDLE && !tempo_zero)
                state_next = RUN;
        end else if (tick) begin
            if (state == RUN && !tempo_zero) begin
                tempo_next = tempo_dec;
                if (tempo_dec == 16'h0000) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end
            end
        end
    end

    // Status outputs decoded from the next state so they land on the same
    // edge as the transition; one-hot decode keeps running/expired exclusive.
    always_comb begin
        running_next = 1'b0;
        expired_next = 1'b0;
        case (state_next)
            RUN:     running_next = 1'b1;
            DONE:    expired_next = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_contador_regressivo.sv
// Self-checking bench for contador_regressivo: table of stimulus/expected
// records run through a scoreboard queue, plus an asynchronous-reset sequence.
module tb_contador_regressivo;

    logic        clock;
    logic        reset;
    logic        tick;
    logic        load;
    logic        start;
    logic        stop;
    logic [15:0] load_value;
    logic [15:0] tempo_bcd;
    logic        running;
    logic        expired;
    logic        done;
    logic        load_err;

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs packed as {tempo_bcd, running, expired, done, load_err}.
    typedef struct {
        logic        ld;
        logic        st;
        logic        sp;
        logic        tk;
        logic [15:0] lv;
        logic [19:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [19:0] exp_q[$];

    contador_regressivo dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .load       (load),
        .start      (start),
        .stop       (stop),
        .load_value (load_value),
        .tempo_bcd  (tempo_bcd),
        .running    (running),
        .expired    (expired),
        .done       (done),
        .load_err   (load_err)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic ld, input logic st, input logic sp,
                                input logic tk, input logic [15:0] lv,
                                input logic [15:0] t, input logic r,
                                input logic e, input logic d, input logic le);
        vec_t v;
        v.ld  = ld;
        v.st  = st;
        v.sp  = sp;
        v.tk  = tk;
        v.lv  = lv;
        v.exp = {t, r, e, d, le};
        return v;
    endfunction

    function automatic logic [19:0] outs();
        return {tempo_bcd, running, expired, done, load_err};
    endfunction

    task automatic check(input string name, input logic [19:0] act,
                         input logic [19:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got tempo=%h r=%b e=%b d=%b le=%b, expected tempo=%h r=%b e=%b d=%b le=%b",
                     name, act[19:4], act[3], act[2], act[1], act[0],
                     exp[19:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drives one vector now, queues its expectation, and compares after the edge.
    task automatic drive_and_check(input string name, input vec_t v);
        logic [19:0] exp;
        load       = v.ld;
        start      = v.st;
        stop       = v.sp;
        tick       = v.tk;
        load_value = v.lv;
        exp_q.push_back(v.exp);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            exp = exp_q.pop_front();
            check(name, outs(), exp);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        @(negedge clock);
        drive_and_check(name, v);
    endtask

    initial begin
        reset      = 1'b0;
        tick       = 1'b0;
        load       = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        load_value = 16'h0000;

        //          ld st sp tk  lv        tempo    r  e  d  le
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0)); // start at 0000
        vecs.push_back(mk(1, 0, 0, 0, 16'h0003, 16'h0003, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0003, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0002, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1, 0)); // reach zero
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0)); // done falls
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0)); // start in DONE
        vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0, 0)); // tick in DONE
        vecs.push_back(mk(1, 0, 0, 0, 16'h0100, 16'h0100, 0, 0, 0, 0)); // load leaves DONE
        vecs.push_back(mk(1, 0, 0, 0, 16'h1000, 16'h1000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h1000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0999, 1, 0, 0, 0)); // full borrow
        vecs.push_back(mk(1, 0, 0, 0, 16'h0A00, 16'h0999, 1, 0, 0, 1)); // bad load in RUN
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0999, 1, 0, 0, 0)); // err one cycle
        vecs.push_back(mk(1, 0, 0, 0, 16'h5959, 16'h5959, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0050, 16'h0050, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0050, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 16'h0050, 0, 0, 0, 0)); // stop beats tick
        vecs.push_back(mk(0, 1, 0, 1, 16'h0000, 16'h0050, 1, 0, 0, 0)); // start beats tick
        vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0049, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0049, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0049, 0, 0, 0, 0)); // stop in IDLE
        vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0049, 0, 0, 0, 0)); // tick in IDLE
        vecs.push_back(mk(1, 1, 0, 0, 16'hF000, 16'h0049, 0, 0, 0, 1)); // bad load beats start
        vecs.push_back(mk(1, 0, 0, 0, 16'h000A, 16'h0049, 0, 0, 0, 1)); // bad low digit
        vecs.push_back(mk(1, 0, 0, 0, 16'h0001, 16'h0001, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0001, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 1, 0, 0)); // stop in DONE
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0)); // load 0000
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0)); // start at 0000
        vecs.push_back(mk(1, 0, 0, 0, 16'h0100, 16'h0100, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0100, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 16'h0099, 1, 0, 0, 0)); // second-digit borrow
        vecs.push_back(mk(1, 1, 0, 0, 16'h9999, 16'h9999, 0, 0, 0, 0)); // load from RUN

        // Reset state, then release between edges.
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", outs(), 20'h00000);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), vecs[i]);

        // Asynchronous reset in the middle of a countdown.
        apply("ar_load", mk(1, 0, 0, 0, 16'h2345, 16'h2345, 0, 0, 0, 0));
        apply("ar_start", mk(0, 1, 0, 0, 16'h0000, 16'h2345, 1, 0, 0, 0));
        apply("ar_tick", mk(0, 0, 0, 1, 16'h0000, 16'h2344, 1, 0, 0, 0));
        @(negedge clock);
        tick  = 1'b0;
        start = 1'b0;
        load  = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        check("ar_async_clear", outs(), 20'h00000);
        tick = 1'b1;
        @(posedge clock);
        #1;
        check("ar_held_in_reset", outs(), 20'h00000);
        @(negedge clock);
        reset = 1'b1;
        drive_and_check("ar_tick_after", mk(0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 0));
        apply("ar_start_zero", mk(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));

        // First edge after release must act on its inputs.
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        drive_and_check("first_edge_load", mk(1, 0, 0, 0, 16'h0007, 16'h0007, 0, 0, 0, 0));
        apply("first_edge_start", mk(0, 1, 0, 0, 16'h0000, 16'h0007, 1, 0, 0, 0));
        apply("first_edge_tick", mk(0, 0, 0, 1, 16'h0000, 16'h0006, 1, 0, 0, 0));

        @(negedge clock);
        tick  = 1'b0;
        start = 1'b0;
        load  = 1'b0;
        stop  = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/contador_regressivo.md
CONTADOR_REGRESSIVO -- requirements
Module: contador_regressivo

Interface
REQ-001 SHALL have port clock  input  1  system clock (50 MHz); all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset; reset=0 forces reset state immediately, independent of clock.
REQ-003 SHALL have port tick  input  1  single-cycle 100 Hz enable pulse synchronous to clock; one tick = one centisecond.
REQ-004 SHALL have port load  input  1  single-cycle pulse; loads load_value.
REQ-005 SHALL have port start  input  1  single-cycle pulse; begins/resumes countdown.
REQ-006 SHALL have port stop  input  1  single-cycle pulse; pauses countdown.
REQ-007 SHALL have port load_value  input  16  BCD {s_dezena, s_unidade, cs_dezena, cs_unidade}, range 00.00-99.99.
REQ-008 SHALL have port tempo_bcd  output  16  current remaining time, same BCD packing as load_value, registered.
REQ-009 SHALL have port running  output  1  high while in state RUN, registered.
REQ-010 SHALL have port expired  output  1  high while in state DONE, registered.
REQ-011 SHALL have port done  output  1  single-cycle pulse on reaching 00.00, registered.
REQ-012 SHALL have port load_err  output  1  single-cycle pulse when a load is rejected, registered.

Function
REQ-013 SHALL implement states IDLE (value held), RUN (counting down), DONE (value 00.00, expired).
REQ-014 SHALL evaluate control inputs per clock edge with priority load > stop > start > tick; lower-priority inputs in the same cycle are ignored.
REQ-015 load with all four digits <= 9: tempo_bcd <= load_value, state -> IDLE, from any state (including RUN and DONE), on that edge.
REQ-016 load with any digit > 9: tempo_bcd and state unchanged; load_err=1 for exactly the following cycle.
REQ-017 stop in RUN -> IDLE, value held; stop in IDLE or DONE has no effect.
REQ-018 start in IDLE with tempo_bcd != 0000 -> RUN; start in IDLE with tempo_bcd = 0000 has no effect; start in RUN or DONE has no effect.
REQ-019 tick in RUN (no higher-priority input) SHALL decrement tempo_bcd by exactly one centisecond on that edge; tick outside RUN ignored.
REQ-020 Decrement SHALL be BCD with borrow chain: cs_unidade 0->9 borrows cs_dezena; cs_dezena 0->9 borrows s_unidade; s_unidade 0->9 borrows s_dezena; no binary intermediate values ever appear on tempo_bcd.
REQ-021 When decrement yields 0000: same edge state -> DONE, done=1 for that one cycle only, running=0, expired=1.
REQ-022 tempo_bcd SHALL never wrap below 0000; in DONE it remains 0000 until load.
REQ-023 running and expired SHALL never be simultaneously high.
REQ-024 Output latency: all outputs reflect the edge on which the input was sampled (one clock, no additional pipeline).

Reset
REQ-025 reset=0 SHALL asynchronously set state IDLE, tempo_bcd=0000, running=0, expired=0, done=0, load_err=0.
REQ-026 reset asserted mid-RUN SHALL abort countdown; after release, block remains IDLE with 0000 until load.
REQ-027 First active edge after reset release SHALL evaluate inputs normally (no lost cycle).

Verification
REQ-028 Load 0x0003, start, 3 ticks -> tempo 0002, 0001, 0000; done pulse exactly once with third tick; expired=1, running=0.
REQ-029 Load 0x1000 (10.00), start, 1 tick -> tempo 0x0999 (09.99), full borrow chain; running stays 1.
REQ-030 Load 0x0A00 -> load_err pulse 1 cycle, tempo unchanged (prior value); load 0x5959 -> accepted, load_err=0.
REQ-031 RUN at 0x0050, same-cycle stop+tick -> IDLE, tempo 0x0050; later start+tick same cycle -> RUN, tempo 0x0050 (tick ignored); next tick -> 0x0049.
REQ-032 Start with tempo 0000 -> stays IDLE; in DONE, start ignored, tick ignored, load 0x0100 -> IDLE, expired=0.
REQ-033 Reset asserted asynchronously mid-cycle during RUN at 0x2345 -> outputs 0000/IDLE before next clock edge; held after release.
